// File: rtl/mem_rd_cmd_splitter.sv
// Read command splitter: turns byte-granular read commands into AXI4 INCR bursts
// (max MAX_BEATS, no 4 KB crossing), throttles in-flight bursts, and streams data back.
module mem_rd_cmd_splitter #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 512,
    parameter int unsigned ID_WIDTH        = 1,
    parameter int unsigned LEN_WIDTH       = 32,
    parameter int unsigned MAX_BEATS       = 64,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic                  mem_clk,
    input  logic                  mem_rst,

    input  logic                  s_cmd_valid,
    output logic                  s_cmd_ready,
    input  logic [ADDR_WIDTH-1:0] s_cmd_addr,
    input  logic [LEN_WIDTH-1:0]  s_cmd_len,

    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,

    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,

    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_data_last,
    output logic                  m_data_valid,
    input  logic                  m_data_ready,

    output logic                  busy,
    output logic                  err
);

    localparam int unsigned BB      = DATA_WIDTH / 8;
    localparam int unsigned BB_LOG2 = $clog2(BB);
    localparam int unsigned REM_W   = LEN_WIDTH - BB_LOG2;
    localparam int unsigned BEAT_W  = 9;
    localparam int unsigned OUT_W   = $clog2(MAX_OUTSTANDING) + 1;
    localparam int unsigned PTR_W   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [REM_W-1:0]      rem_beats_q, rem_beats_d;
    logic [OUT_W-1:0]      out_q, out_d;
    logic [MAX_OUTSTANDING-1:0] flag_q;
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic                  err_q;

    logic [12:0]           dist_bytes;
    logic [BEAT_W-1:0]     dist_beats;
    logic [BEAT_W-1:0]     beats;
    logic                  cmd_ready_c;
    logic                  arvalid_c;
    logic                  ar_hs;
    logic                  r_hs;
    logic                  r_last_hs;
    logic                  rready_c;
    logic                  fifo_push;
    logic                  final_flag;
    logic                  unused_rid;

    // Burst length: bounded by remaining beats, MAX_BEATS and the next 4 KB page edge.
    assign dist_bytes = 13'h1000 - {1'b0, cur_addr_q[11:0]};
    assign dist_beats = BEAT_W'(dist_bytes >> BB_LOG2);

    always_comb begin
        beats = BEAT_W'(MAX_BEATS);
        if (dist_beats < beats) begin
            beats = dist_beats;
        end
        if (rem_beats_q < REM_W'(beats)) begin
            beats = BEAT_W'(rem_beats_q);
        end
    end

    // Next-state and handshake logic.
    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        rem_beats_d = rem_beats_q;
        cmd_ready_c = 1'b0;
        arvalid_c   = 1'b0;
        fifo_push   = 1'b0;
        final_flag  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cmd_ready_c = !mem_rst;
                if (s_cmd_valid && cmd_ready_c) begin
                    cur_addr_d  = s_cmd_addr & ~ADDR_WIDTH'(BB - 1);
                    rem_beats_d = REM_W'(s_cmd_len >> BB_LOG2);
                    if (rem_beats_d != '0) begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                // Outstanding only drops while AR is pending, so arvalid never retracts.
                arvalid_c = (out_q < OUT_W'(MAX_OUTSTANDING)) && !mem_rst;
                if (arvalid_c && m_axi_arready) begin
                    cur_addr_d  = cur_addr_q + (ADDR_WIDTH'(beats) << BB_LOG2);
                    rem_beats_d = rem_beats_q - REM_W'(beats);
                    fifo_push   = 1'b1;
                    final_flag  = (rem_beats_q == REM_W'(beats));
                    if (final_flag) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ar_hs     = arvalid_c && m_axi_arready;
    assign rready_c  = m_data_ready && !mem_rst;
    assign r_hs      = m_axi_rvalid && rready_c;
    assign r_last_hs = r_hs && m_axi_rlast;

    always_comb begin
        out_d = out_q;
        if (ar_hs && !r_last_hs) begin
            out_d = out_q + OUT_W'(1);
        end else if (!ar_hs && r_last_hs) begin
            out_d = out_q - OUT_W'(1);
        end
    end

    always_ff @(posedge mem_clk) begin
        if (mem_rst) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            rem_beats_q <= '0;
            out_q       <= '0;
            flag_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            rem_beats_q <= rem_beats_d;
            out_q       <= out_d;
            if (fifo_push) begin
                flag_q[wr_ptr_q] <= final_flag;
                wr_ptr_q <= (wr_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (r_last_hs) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            if (r_hs && (m_axi_rresp != 2'b00)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign s_cmd_ready   = cmd_ready_c;
    assign m_axi_araddr  = cur_addr_q;
    assign m_axi_arlen   = 8'(beats - BEAT_W'(1));
    assign m_axi_arsize  = 3'(BB_LOG2);
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arid    = '0;
    assign m_axi_arvalid = arvalid_c;

    assign m_axi_rready  = rready_c;
    assign m_data        = m_axi_rdata;
    assign m_data_valid  = m_axi_rvalid && !mem_rst;
    assign m_data_last   = m_axi_rlast && flag_q[rd_ptr_q];

    assign busy          = (state_q != IDLE) || (out_q != '0);
    assign err           = err_q;

    // A single ID keeps responses in order, so rid carries no information.
    assign unused_rid    = ^m_axi_rid;

endmodule

// File: tb/tb_mem_rd_cmd_splitter.sv
// Directed bench for mem_rd_cmd_splitter with an AXI read slave model and
// scoreboard queues for expected AR bursts and output beats.
module tb_mem_rd_cmd_splitter;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_t;

    typedef struct {
        logic [511:0] data;
        logic         last;
    } dat_t;

    typedef struct {
        logic [511:0] data;
        logic         last;
        logic [1:0]   resp;
    } rb_t;

    logic         mem_clk;
    logic         mem_rst;
    logic         s_cmd_valid;
    logic         s_cmd_ready;
    logic [31:0]  s_cmd_addr;
    logic [31:0]  s_cmd_len;
    logic [31:0]  m_axi_araddr;
    logic [7:0]   m_axi_arlen;
    logic [2:0]   m_axi_arsize;
    logic [1:0]   m_axi_arburst;
    logic         m_axi_arlock;
    logic [3:0]   m_axi_arcache;
    logic [2:0]   m_axi_arprot;
    logic [0:0]   m_axi_arid;
    logic         m_axi_arvalid;
    logic         m_axi_arready;
    logic [0:0]   m_axi_rid;
    logic [511:0] m_axi_rdata;
    logic [1:0]   m_axi_rresp;
    logic         m_axi_rlast;
    logic         m_axi_rvalid;
    logic         m_axi_rready;
    logic [511:0] m_data;
    logic         m_data_last;
    logic         m_data_valid;
    logic         m_data_ready;
    logic         busy;
    logic         err;

    mem_rd_cmd_splitter dut (
        .mem_clk       (mem_clk),
        .mem_rst       (mem_rst),
        .s_cmd_valid   (s_cmd_valid),
        .s_cmd_ready   (s_cmd_ready),
        .s_cmd_addr    (s_cmd_addr),
        .s_cmd_len     (s_cmd_len),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_arlock  (m_axi_arlock),
        .m_axi_arcache (m_axi_arcache),
        .m_axi_arprot  (m_axi_arprot),
        .m_axi_arid    (m_axi_arid),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rid     (m_axi_rid),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .m_data        (m_data),
        .m_data_last   (m_data_last),
        .m_data_valid  (m_data_valid),
        .m_data_ready  (m_data_ready),
        .busy          (busy),
        .err           (err)
    );

    initial begin
        mem_clk = 1'b0;
        forever #5 mem_clk = ~mem_clk;
    end

    int   checks = 0;
    int   errors = 0;
    int   cyc_n = 0;
    int   ar_cnt = 0;
    int   ar_cyc = -1;
    int   rlast_cyc = -1;
    int   slave_beats = 0;
    int   inj_beat = -1;
    logic r_en = 1'b0;
    logic rdy_toggle = 1'b0;
    logic err_pend = 1'b0;

    logic        cmd_hs_s, rdy_s, arv_s, busy_s, err_s, mdv_s, rr_s;
    logic [31:0] araddr_s;

    ar_t  exp_ar[$];
    dat_t exp_dat[$];
    rb_t  rq[$];

    function automatic logic [511:0] pat(input logic [31:0] a);
        return {16{a ^ 32'h5A5A_0000}};
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected bursts and beats for one command, derived from address and length alone.
    task automatic push_cmd(input logic [31:0] addr, input logic [31:0] len);
        logic [31:0] a;
        int unsigned rem, b, d;
        a   = addr & ~32'h3F;
        rem = len >> 6;
        for (int i = 0; i < int'(rem); i++) begin
            exp_dat.push_back('{pat(a + 32'(i) * 32'd64), (i == int'(rem) - 1)});
        end
        while (rem > 0) begin
            b = 64;
            d = (4096 - int'(a[11:0])) / 64;
            if (d < b) b = d;
            if (rem < b) b = rem;
            exp_ar.push_back('{a, 8'(b - 1)});
            a   = a + 32'(b * 64);
            rem = rem - b;
        end
    endtask

    // One clock: drive slave R channel, sample at edge+3, score handshakes, advance.
    task automatic cyc();
        ar_t  ea;
        dat_t ed;
        if (r_en && rq.size() > 0) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = rq[0].data;
            m_axi_rlast  = rq[0].last;
            m_axi_rresp  = rq[0].resp;
        end else begin
            m_axi_rvalid = 1'b0;
            m_axi_rdata  = '0;
            m_axi_rlast  = 1'b0;
            m_axi_rresp  = 2'b00;
        end
        if (rdy_toggle) m_data_ready = (cyc_n % 2 == 0);
        #2;
        cmd_hs_s = s_cmd_valid && s_cmd_ready;
        rdy_s    = s_cmd_ready;
        arv_s    = m_axi_arvalid;
        araddr_s = m_axi_araddr;
        busy_s   = busy;
        err_s    = err;
        mdv_s    = m_data_valid;
        rr_s     = m_axi_rready;
        if (err_pend) begin
            chk("err_set", err, 1'b1);
            err_pend = 1'b0;
        end
        if (m_axi_arvalid && m_axi_arready) begin
            ar_cnt++;
            ar_cyc = cyc_n;
            checks++;
            assert (exp_ar.size() > 0) else begin
                errors++;
                $error("FAIL ar_extra observed araddr=%0h expected no AR", m_axi_araddr);
            end
            if (exp_ar.size() > 0) begin
                ea = exp_ar.pop_front();
                chk("araddr", m_axi_araddr, ea.addr);
                chk("arlen", m_axi_arlen, ea.len);
                chk("ar_const", {m_axi_arsize, m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arid},
                    {3'd6, 2'b01, 1'b0, 4'b0011, 3'b000, 1'b0});
            end
            for (int i = 0; i <= int'(m_axi_arlen); i++) begin
                rq.push_back('{pat(m_axi_araddr + 32'(i) * 32'd64), (i == int'(m_axi_arlen)),
                               (slave_beats == inj_beat) ? 2'b10 : 2'b00});
                slave_beats++;
            end
        end
        if (m_data_valid && m_data_ready) begin
            checks++;
            assert (exp_dat.size() > 0) else begin
                errors++;
                $error("FAIL beat_extra observed data=%0h expected no beat", m_data);
            end
            if (exp_dat.size() > 0) begin
                ed = exp_dat.pop_front();
                chk("m_data", m_data, ed.data);
                chk("m_data_last", m_data_last, ed.last);
            end
        end
        if (m_axi_rvalid && m_axi_rready && rq.size() > 0) begin
            if (rq[0].resp != 2'b00) err_pend = 1'b1;
            if (rq[0].last) rlast_cyc = cyc_n;
            rq.delete(0);
        end
        @(posedge mem_clk);
        #1;
        cyc_n++;
    endtask

    task automatic send_cmd(input logic [31:0] addr, input logic [31:0] len);
        int n;
        push_cmd(addr, len);
        s_cmd_valid = 1'b1;
        s_cmd_addr  = addr;
        s_cmd_len   = len;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!cmd_hs_s && n < 50);
        chk("cmd_accept", cmd_hs_s, 1'b1);
        s_cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        int n;
        n = 0;
        while ((exp_dat.size() > 0 || exp_ar.size() > 0) && n < bound) begin
            cyc();
            n++;
        end
        chk("drain_left", 32'(exp_dat.size() + exp_ar.size()), 32'd0);
        cyc();
        chk("busy_drop", busy_s, 1'b0);
    endtask

    initial begin
        int ar_base;
        int n;
        mem_rst       = 1'b1;
        s_cmd_valid   = 1'b0;
        s_cmd_addr    = '0;
        s_cmd_len     = '0;
        m_axi_arready = 1'b1;
        m_axi_rid     = '0;
        m_axi_rdata   = '0;
        m_axi_rresp   = 2'b00;
        m_axi_rlast   = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_data_ready  = 1'b1;
        @(posedge mem_clk);
        #1;

        // Reset: a pending R beat must not be accepted or forwarded
        rq.push_back('{pat(32'h0), 1'b1, 2'b00});
        r_en = 1'b1;
        cyc();
        cyc();
        chk("rst_cmd_ready", rdy_s, 1'b0);
        chk("rst_rready", rr_s, 1'b0);
        chk("rst_mdata_valid", mdv_s, 1'b0);
        chk("rst_arvalid", arv_s, 1'b0);
        mem_rst = 1'b0;
        rq.delete();
        cyc();
        chk("post_rst_cmd_ready", rdy_s, 1'b1);
        chk("post_rst_busy", busy_s, 1'b0);
        chk("post_rst_err", err_s, 1'b0);

        // Single full 4 KB page burst
        send_cmd(32'h0, 32'd4096);
        wait_drain(300);

        // Page-crossing split
        send_cmd(32'h0000_0FC0, 32'd256);
        wait_drain(100);

        // Outstanding throttle with no data returning
        r_en    = 1'b0;
        ar_base = ar_cnt;
        send_cmd(32'h0, 32'd65536);
        repeat (12) cyc();
        chk("throttle_ar_cnt", 32'(ar_cnt - ar_base), 32'd8);
        chk("throttle_araddr", araddr_s, 32'h0000_8000);
        r_en = 1'b1;
        n = 0;
        while (ar_cnt - ar_base < 9 && n < 200) begin
            cyc();
            n++;
        end
        chk("ar9_after_rlast", 32'(ar_cyc), 32'(rlast_cyc + 1));
        wait_drain(3000);

        // Zero-beat commands are dropped
        ar_base = ar_cnt;
        send_cmd(32'h0000_0100, 32'd0);
        cyc();
        chk("len0_ready", rdy_s, 1'b1);
        chk("len0_busy", busy_s, 1'b0);
        send_cmd(32'h0000_0200, 32'd63);
        cyc();
        chk("len63_ready", rdy_s, 1'b1);
        repeat (3) cyc();
        chk("len_small_no_ar", 32'(ar_cnt - ar_base), 32'd0);

        // Back-to-back commands with output backpressure
        rdy_toggle = 1'b1;
        send_cmd(32'h0000_2000, 32'd128);
        send_cmd(32'h0000_3000, 32'd128);
        wait_drain(100);
        rdy_toggle   = 1'b0;
        m_data_ready = 1'b1;

        // Error response on the second beat of a burst
        chk("err_clear_before", err_s, 1'b0);
        inj_beat = slave_beats + 1;
        send_cmd(32'h0000_4000, 32'd256);
        wait_drain(100);
        chk("err_sticky", err_s, 1'b1);
        inj_beat = -1;

        // Reset in the middle of a burst
        send_cmd(32'h0, 32'd4096);
        repeat (10) cyc();
        mem_rst = 1'b1;
        cyc();
        mem_rst = 1'b0;
        exp_ar.delete();
        exp_dat.delete();
        rq.delete();
        err_pend = 1'b0;
        cyc();
        chk("midrst_arvalid", arv_s, 1'b0);
        chk("midrst_busy", busy_s, 1'b0);
        chk("midrst_err", err_s, 1'b0);
        chk("midrst_cmd_ready", rdy_s, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
